// File: rtl/fp_arb_pkg.sv
// Shared types for the fp_dw adder arbiter: widths, add/sub mode encoding, in-flight tag and lock FSM states.
// The lock feature of fp_adder_arbiter is enabled by defining FP_ARB_LOCK_EN.
package fp_arb_pkg;

   localparam int FP_W      = 48;
   localparam int MAX_NREQ  = 8;
   // Tag ids are sized for the largest supported requester count so one tag type serves every build.
   localparam int ID_W      = $clog2(MAX_NREQ);

   typedef enum logic {
      FP_ADD = 1'b0,
      FP_SUB = 1'b1
   } fp_mode_e;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, optionally restricted to the lock owner.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] reqValid,
   input  logic [IDW-1:0]  ptr,
   input  logic            lockActive,
   input  logic [IDW-1:0]  owner,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grantIdx
);

   logic [NREQ-1:0] masked;
   logic            found;
   int              idx;

   assign masked = lockActive ? (reqValid & (NREQ'(1) << owner)) : reqValid;

   always_comb begin
      grant    = '0;
      grantIdx = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && masked[idx]) begin
            found       = 1'b1;
            grantIdx    = IDW'(idx);
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one fp_dw adder between NREQ requesters: round-robin issue, registered operands, tag pipeline for results.
// Define FP_ARB_LOCK_EN to add req_lock and the ARB/LOCKED ownership FSM.
module fp_adder_arbiter #(
   parameter int NREQ   = 4,
   parameter int FP_W   = fp_arb_pkg::FP_W,
   parameter int FP_LAT = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*FP_W-1:0]   req_in1,
   input  logic [NREQ*FP_W-1:0]   req_in2,
   input  logic [NREQ-1:0]        req_mode,
`ifdef FP_ARB_LOCK_EN
   input  logic [NREQ-1:0]        req_lock,
`endif
   output logic [NREQ-1:0]        rsp_valid,
   output logic [FP_W-1:0]        rsp_data,
   output logic [FP_W-1:0]        fp_in1,
   output logic [FP_W-1:0]        fp_in2,
   output logic                   fp_mode,
   input  logic [FP_W-1:0]        fp_out,
   output logic                   busy,
   output fp_arb_pkg::arb_state_e arbState
);
   import fp_arb_pkg::*;

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grantIdx;
   logic            handshake;
   logic            lockActive;
   logic [IDW-1:0]  owner;
   logic [FP_W-1:0] selIn1, selIn2;
   logic            selMode;
   logic [NREQ-1:0] rspNext;
   tag_t            newTag;
   tag_t            tagPipe [FP_LAT+1];

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .reqValid  (req_valid),
      .ptr       (ptr),
      .lockActive(lockActive),
      .owner     (owner),
      .grant     (grant),
      .grantIdx  (grantIdx)
   );

   // Handshake: an op transfers when req_valid[i] && req_ready[i]; requesters hold valid/operands
   // until ready and never derive valid from ready. Ready is suppressed while reset is low.
   assign req_ready = grant & {NREQ{reset}};
   assign handshake = |req_ready;

   always_comb begin
      selIn1  = '0;
      selIn2  = '0;
      selMode = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            selIn1  = req_in1[i*FP_W +: FP_W];
            selIn2  = req_in2[i*FP_W +: FP_W];
            selMode = req_mode[i];
         end
      end
      newTag.valid = handshake;
      newTag.id    = ID_W'(grantIdx);
   end

   always_comb begin
      rspNext = '0;
      for (int i = 0; i < NREQ; i++)
         rspNext[i] = tagPipe[FP_LAT].valid && (tagPipe[FP_LAT].id == ID_W'(i));
      busy = |rsp_valid;
      for (int s = 0; s <= FP_LAT; s++)
         busy = busy | tagPipe[s].valid;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr       <= '0;
         fp_in1    <= '0;
         fp_in2    <= '0;
         fp_mode   <= FP_ADD;
         rsp_valid <= '0;
         rsp_data  <= '0;
         for (int s = 0; s <= FP_LAT; s++) tagPipe[s] <= '0;
      end else begin
         if (handshake) begin
            ptr     <= (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
            fp_in1  <= selIn1;
            fp_in2  <= selIn2;
            fp_mode <= selMode ? FP_SUB : FP_ADD;
         end
         tagPipe[0] <= newTag;
         for (int s = 1; s <= FP_LAT; s++) tagPipe[s] <= tagPipe[s-1];
         // The oldest tag lines up with fp_out, so results retire in issue order.
         rsp_valid <= rspNext;
         if (tagPipe[FP_LAT].valid) rsp_data <= fp_out;
      end
   end

`ifdef FP_ARB_LOCK_EN
   arb_state_e     state, stateNext;
   logic [IDW-1:0] ownerNext;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ARB;
         owner <= '0;
      end else begin
         state <= stateNext;
         owner <= ownerNext;
      end
   end

   // While LOCKED only the owner can be granted, so any handshake here is the owner's.
   always_comb begin
      stateNext = state;
      ownerNext = owner;
      case (state)
         ARB:     if (handshake && req_lock[grantIdx]) begin
                     stateNext = LOCKED;
                     ownerNext = grantIdx;
                  end
         LOCKED:  if (handshake && !req_lock[grantIdx]) stateNext = ARB;
         default: stateNext = ARB;
      endcase
   end

   assign lockActive = (state == LOCKED);
   assign arbState   = state;
`else
   assign lockActive = 1'b0;
   assign owner      = '0;
   assign arbState   = ARB;
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter (NREQ=4, FP_LAT=1); define FP_ARB_LOCK_EN to also exercise the lock FSM.
module tb_fp_adder_arbiter;
   import fp_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int W    = 48;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [NREQ-1:0]   req_valid, req_ready, req_mode, rsp_valid;
   logic [NREQ*W-1:0] req_in1, req_in2;
   logic [W-1:0]      rsp_data, fp_in1, fp_in2, fp_out;
   logic              fp_mode, busy;
   arb_state_e        arbState;
`ifdef FP_ARB_LOCK_EN
   logic [NREQ-1:0]   req_lock;
`endif

   int errors = 0;
   int checks = 0;

   logic [3:0]   t3Ready [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
   logic [3:0]   t3Rsp   [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
   logic [W-1:0] t3Data  [9] = '{48'd0, 48'd0, 48'd0, 48'd1234, 48'd3500, 48'd70007, 48'hFFFF_FFFF_FFFF, 48'd1234, 48'd0};
   logic [W-1:0] t4In1   [5] = '{48'd1000, 48'd2000, 48'd3000, 48'd4000, 48'd5000};
   logic [W-1:0] t4In2   [5] = '{48'd1, 48'd2, 48'd3, 48'd4, 48'd5};
   logic [W-1:0] t4Res   [5] = '{48'd999, 48'd1998, 48'd2997, 48'd3996, 48'd4995};

   fp_adder_arbiter #(.NREQ(NREQ), .FP_W(W), .FP_LAT(1)) dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_in1  (req_in1),
      .req_in2  (req_in2),
      .req_mode (req_mode),
`ifdef FP_ARB_LOCK_EN
      .req_lock (req_lock),
`endif
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .fp_in1   (fp_in1),
      .fp_in2   (fp_in2),
      .fp_mode  (fp_mode),
      .fp_out   (fp_out),
      .busy     (busy),
      .arbState (arbState)
   );

   // clock / adder model block: one register stage, integer add/sub stands in for fp_dw
   always #5 clock = ~clock;
   always @(posedge clock) fp_out <= fp_mode ? (fp_in1 - fp_in2) : (fp_in1 + fp_in2);

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setOp(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      req_in1[i*W +: W] = a;
      req_in2[i*W +: W] = b;
      req_mode[i]       = m;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_valid = '1;
      req_in1   = '0;
      req_in2   = '0;
      req_mode  = '0;
`ifdef FP_ARB_LOCK_EN
      req_lock  = '0;
`endif
      // reset state, with requests pending that must not be accepted
      @(negedge clock);
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fp_in1", fp_in1, 48'd0);
      chk("rst_fp_mode", fp_mode, 1'b0);
      chk("rst_rsp_data", rsp_data, 48'd0);
      chk("rst_state", arbState, ARB);

      // two requesters from ptr=0
      tick();
      reset = 1'b1;
      req_valid = 4'b0011;
      setOp(0, 48'd100, 48'd30, 1'b0);
      setOp(1, 48'd500, 48'd200, 1'b1);
      @(negedge clock);
      chk("t2_c0_ready", req_ready, 4'b0001);
      chk("t2_c0_busy", busy, 1'b0);
      tick(); req_valid[0] = 1'b0;
      @(negedge clock);
      chk("t2_c1_ready", req_ready, 4'b0010);
      chk("t2_c1_in1", fp_in1, 48'd100);
      chk("t2_c1_mode", fp_mode, 1'b0);
      tick(); req_valid[1] = 1'b0;
      @(negedge clock);
      chk("t2_c2_ready", req_ready, 4'b0000);
      chk("t2_c2_in1", fp_in1, 48'd500);
      chk("t2_c2_in2", fp_in2, 48'd200);
      chk("t2_c2_mode", fp_mode, 1'b1);
      chk("t2_c2_rsp", rsp_valid, 4'b0000);
      chk("t2_c2_busy", busy, 1'b1);
      tick();
      @(negedge clock);
      chk("t2_c3_rsp", rsp_valid, 4'b0001);
      chk("t2_c3_data", rsp_data, 48'd130);
      tick();
      @(negedge clock);
      chk("t2_c4_rsp", rsp_valid, 4'b0010);
      chk("t2_c4_data", rsp_data, 48'd300);
      tick();
      @(negedge clock);
      chk("t2_c5_rsp", rsp_valid, 4'b0000);
      chk("t2_c5_busy", busy, 1'b0);

      // reset with two ops in flight (ptr is 2 here)
      tick();
      req_valid = 4'b1100;
      setOp(2, 48'd11, 48'd22, 1'b0);
      setOp(3, 48'd33, 48'd44, 1'b1);
      @(negedge clock);
      chk("t1_ready2", req_ready, 4'b0100);
      tick(); req_valid[2] = 1'b0;
      @(negedge clock);
      chk("t1_ready3", req_ready, 4'b1000);
      tick(); req_valid[3] = 1'b0;
      @(negedge clock);
      chk("t1_busy_inflight", busy, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("t1_fp_in1", fp_in1, 48'd0);
      chk("t1_fp_in2", fp_in2, 48'd0);
      chk("t1_fp_mode", fp_mode, 1'b0);
      chk("t1_rsp_data", rsp_data, 48'd0);
      chk("t1_rsp_valid", rsp_valid, 4'b0000);
      chk("t1_busy", busy, 1'b0);
      @(posedge clock);
      #1 reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("t1_post_rsp", rsp_valid, 4'b0000);
         chk("t1_post_busy", busy, 1'b0);
      end

      // all four requesters valid continuously (ptr back to 0)
      tick();
      setOp(0, 48'd1000, 48'd234, 1'b0);
      setOp(1, 48'd5000, 48'd1500, 1'b1);
      setOp(2, 48'd70000, 48'd7, 1'b0);
      setOp(3, 48'd9, 48'd10, 1'b1);
      req_valid = 4'b1111;
      for (int e = 0; e < 9; e++) begin
         @(negedge clock);
         chk("t3_ready", req_ready, t3Ready[e]);
         chk("t3_rsp", rsp_valid, t3Rsp[e]);
         if (t3Rsp[e] != 4'b0000) chk("t3_data", rsp_data, t3Data[e]);
         tick();
         if (e == 4) req_valid = 4'b0000;
      end

      // requester 2 alone, five back-to-back subtracts; issues overlap its own results
      req_valid = 4'b0100;
      setOp(2, t4In1[0], t4In2[0], 1'b1);
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         chk("t4_ready", req_ready, (k < 5) ? 4'b0100 : 4'b0000);
         chk("t4_rsp", rsp_valid, (k >= 3 && k <= 7) ? 4'b0100 : 4'b0000);
         if (k >= 1 && k <= 5) begin
            chk("t4_mode", fp_mode, 1'b1);
            chk("t4_in1", fp_in1, t4In1[k-1]);
         end
         if (k >= 3 && k <= 7) chk("t4_data", rsp_data, t4Res[k-3]);
         if (k == 8) chk("t4_busy", busy, 1'b0);
         tick();
         if (k < 4) setOp(2, t4In1[k+1], t4In2[k+1], 1'b1);
         else req_valid = 4'b0000;
      end

`ifdef FP_ARB_LOCK_EN
      // req0 locks (ptr is 3); req1 waits until req0 issues with lock released
      req_valid = 4'b0011;
      req_lock  = 4'b0001;
      setOp(0, 48'd1, 48'd2, 1'b0);
      setOp(1, 48'd3, 48'd4, 1'b0);
      @(negedge clock);
      chk("t5_lock_grant", req_ready, 4'b0001);
      tick(); req_valid[0] = 1'b0;
      @(negedge clock);
      chk("t5_locked_wait1", req_ready, 4'b0000);
      chk("t5_state_locked", arbState, LOCKED);
      tick();
      @(negedge clock);
      chk("t5_locked_wait2", req_ready, 4'b0000);
      tick(); req_valid[0] = 1'b1; req_lock[0] = 1'b0;
      @(negedge clock);
      chk("t5_unlock_grant", req_ready, 4'b0001);
      tick(); req_valid[0] = 1'b0;
      @(negedge clock);
      chk("t5_req1_grant", req_ready, 4'b0010);
      chk("t5_state_arb", arbState, ARB);
      tick(); req_valid = 4'b0000;
      repeat (4) tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
